mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit that sits between the 2-read/1-write register file's read ports and its write port. It captures the two source operands read from the register file, computes one RISC-V M-extension result over 33+ cycles, and presents the result on a write-back interface that drives the register file's write data, register number and write enable. Only one operation is in flight at a time; a start/ready handshake issues work, and a `wbReady` input stalls write-back.

## Interface
- `DATA_WIDTH`, 32, operand/result width; matches DataPath
- `REG_NUM_WIDTH`, 5, destination register number width; matches RegNumPath
- `clk`  in  1  clock; all state changes on the rising edge
- `rstN`  in  1  reset; synchronous, active-low
- `start`  in  1  issue request; accepted only when `ready`=1
- `op`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `srcA`  in  DATA_WIDTH  operand A (rs1 / dividend); from register-file read port A
- `srcB`  in  DATA_WIDTH  operand B (rs2 / divisor); from register-file read port B
- `dstNum`  in  REG_NUM_WIDTH  destination register
- `flush`  in  1  abort any in-flight operation
- `ready`  out  1  unit idle, can accept `start`
- `busy`  out  1  operation captured, result not yet written back
- `wbReady`  in  1  write port available this cycle
- `wrData`  out  DATA_WIDTH  result to register-file write data
- `wrNum`  out  REG_NUM_WIDTH  to register-file write register number
- `wrEnable`  out  1  write strobe; single-cycle pulse per completed operation

## Operation
- FSM: IDLE, CALC, DONE.
- IDLE: `ready`=1. `start`=1 and `flush`=0 -> latch `op`, `dstNum`, operand magnitudes and result sign; clear the 6-bit counter; go to CALC. `start` while not IDLE is ignored; no error is flagged.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned. Signed operands are converted to magnitude at capture; the sign is applied once at the end.
- Multiply: shift-add, one partial product per cycle, 64-bit accumulator, 32 CALC cycles. MUL returns the low 32 bits; the MULH variants return the high 32 bits of the signed-corrected product. Negation is applied to the full 64 bits.
- Divide: restoring, one quotient bit per cycle, 32 CALC cycles.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Divide by zero (decided at capture, still 32 cycles):
  - DIV/DIVU -> 0xFFFFFFFF.
  - REM/REMU -> srcA unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- After counter reaches 31 -> DONE with the result registered in `wrData`.
- DONE: `wrEnable` = `wbReady` AND (`wrNum` != 0).
  - `wbReady`=1 -> return to IDLE next cycle.
  - `wbReady`=0 -> hold DONE with `wrData` and `wrNum` stable.
  - `wrNum`=0 -> no write strobe, but the unit still leaves DONE when `wbReady`=1.
- `flush`=1 in any state -> IDLE next cycle, no write. `flush` has priority over `start` and over a DONE write: `wrEnable` is forced 0 in that cycle.

## Timing
- Reset (`rstN`=0 at an edge): state IDLE, `ready`=1, `busy`=0, `wrEnable`=0, `wrData`=0, `wrNum`=0, counter=0. Reset mid-CALC or mid-DONE discards the operation, with no write.
- `ready` = (state==IDLE); `busy` = not `ready`. Both are decoded from registered state.
- Latency: `start` accepted at edge T0 -> CALC during cycles 1..32 -> DONE visible in cycle 33. With `wbReady`=1, `wrEnable` is high in cycle 33 and `ready`=1 in cycle 34.
- Throughput: one operation per 34 cycles. Back-to-back `start` is legal in the first cycle `ready`=1.
- `wrEnable` is combinational from the DONE state, `wbReady`, `flush` and `wrNum`. It is high for exactly one cycle per committed result.
- Operands are sampled only at the accept edge. Later changes on `srcA`, `srcB`, `op` and `dstNum` have no effect.

## Test plan
- MUL 7 × 6 to r5, `wbReady`=1 -> `wrEnable` in cycle 33, `wrNum`=5, `wrData`=42, `ready` in cycle 34.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHU with the same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- Edge cases:
  - DIV 0x12345678 / 0 -> 0xFFFFFFFF.
  - REM 0x12345678 / 0 -> 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Write-back stall: hold `wbReady`=0 for 5 cycles in DONE -> `wrEnable`=0 and `wrData` stable throughout. Raise `wbReady` -> exactly one `wrEnable` pulse. Destination r0 -> no pulse, but `ready` returns.
- Flush and reset: `flush` at CALC cycle 10 -> IDLE next cycle, no write. `rstN`=0 during DONE -> all outputs at reset values next cycle. A second `start` during CALC is ignored, and the first result is unchanged.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// Module : mul_div_unit_if
// Brief  : Issue and write-back bundle between the register file and the
//          iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul_div_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
);
  logic                     start;
  logic [2:0]               op;
  logic [DATA_WIDTH-1:0]    srcA;
  logic [DATA_WIDTH-1:0]    srcB;
  logic [REG_NUM_WIDTH-1:0] dstNum;
  logic                     flush;
  logic                     ready;
  logic                     busy;
  logic                     wbReady;
  logic [DATA_WIDTH-1:0]    wrData;
  logic [REG_NUM_WIDTH-1:0] wrNum;
  logic                     wrEnable;

  modport master (
    output start, op, srcA, srcB, dstNum, flush, wbReady,
    input  ready, busy, wrData, wrNum, wrEnable
  );

  modport slave (
    input  start, op, srcA, srcB, dstNum, flush, wbReady,
    output ready, busy, wrData, wrNum, wrEnable
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Iterative RISC-V M-extension multiply/divide, one bit per cycle,
//          with a stallable register-file write-back port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rstN,
  mul_div_unit_if.slave  bus
);

  localparam int          DW         = DATA_WIDTH;
  localparam logic [2:0]  c_OP_MUL    = 3'd0;
  localparam logic [2:0]  c_OP_MULH   = 3'd1;
  localparam logic [2:0]  c_OP_MULHSU = 3'd2;
  localparam logic [2:0]  c_OP_MULHU  = 3'd3;
  localparam logic [2:0]  c_OP_DIV    = 3'd4;
  localparam logic [2:0]  c_OP_DIVU   = 3'd5;
  localparam logic [2:0]  c_OP_REM    = 3'd6;
  localparam logic [5:0]  c_LAST_STEP = 6'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [2:0]               r_op;
  logic [REG_NUM_WIDTH-1:0] r_dst;
  logic [5:0]               r_count;
  logic [DW-1:0]            r_operand;
  logic [2*DW-1:0]          r_acc;
  logic                     r_signA;
  logic                     r_signB;
  logic                     r_divZero;
  logic [DW-1:0]            r_wrData;

  // Capture-side operand conditioning
  logic          w_isMul;
  logic          w_aSigned;
  logic          w_bSigned;
  logic          w_signA;
  logic          w_signB;
  logic [DW-1:0] w_magA;
  logic [DW-1:0] w_magB;

  always_comb begin
    w_isMul   = ~bus.op[2];
    w_aSigned = (bus.op == c_OP_MUL) || (bus.op == c_OP_MULH) ||
                (bus.op == c_OP_MULHSU) || (bus.op == c_OP_DIV) ||
                (bus.op == c_OP_REM);
    w_bSigned = w_aSigned && (bus.op != c_OP_MULHSU);
    w_signA   = w_aSigned && bus.srcA[DW-1];
    w_signB   = w_bSigned && bus.srcB[DW-1];
    w_magA    = w_signA ? -bus.srcA : bus.srcA;
    w_magB    = w_signB ? -bus.srcB : bus.srcB;
  end

  // Accumulator is {high/remainder, low/quotient}: multiply shifts right,
  // divide shifts left, so one register serves both.
  logic [DW:0]     w_mulSum;
  logic [DW:0]     w_divShift;
  logic [DW:0]     w_divTrial;
  logic [2*DW-1:0] w_nextAcc;

  always_comb begin
    w_mulSum   = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    w_divShift = r_acc[2*DW-1:DW-1];
    w_divTrial = w_divShift - {1'b0, r_operand};
    if (!r_op[2]) begin
      w_nextAcc = {w_mulSum, r_acc[DW-1:1]};
    end else if (w_divTrial[DW]) begin
      w_nextAcc = {w_divShift[DW-1:0], r_acc[DW-2:0], 1'b0};
    end else begin
      w_nextAcc = {w_divTrial[DW-1:0], r_acc[DW-2:0], 1'b1};
    end
  end

  logic            w_negResult;
  logic [2*DW-1:0] w_prodSigned;
  logic [DW-1:0]   w_quot;
  logic [DW-1:0]   w_rem;
  logic [DW-1:0]   w_result;

  always_comb begin
    w_negResult  = r_signA ^ r_signB;
    w_prodSigned = w_negResult ? -w_nextAcc : w_nextAcc;
    w_quot       = w_negResult ? -w_nextAcc[DW-1:0] : w_nextAcc[DW-1:0];
    w_rem        = r_signA ? -w_nextAcc[2*DW-1:DW] : w_nextAcc[2*DW-1:DW];
    case (r_op)
      c_OP_MUL:                           w_result = w_prodSigned[DW-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_prodSigned[2*DW-1:DW];
      c_OP_DIV, c_OP_DIVU:                w_result = r_divZero ? '1 : w_quot;
      default:                            w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_dst     <= '0;
      r_count   <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_divZero <= 1'b0;
      r_wrData  <= '0;
    end else if (bus.flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= CALC;
            r_op      <= bus.op;
            r_dst     <= bus.dstNum;
            r_count   <= '0;
            r_signA   <= w_signA;
            r_signB   <= w_signB;
            r_divZero <= bus.op[2] && (bus.srcB == '0);
            r_operand <= w_isMul ? w_magA : w_magB;
            r_acc     <= {{DW{1'b0}}, (w_isMul ? w_magB : w_magA)};
          end
        end
        CALC: begin
          r_acc   <= w_nextAcc;
          r_count <= r_count + 6'd1;
          if (r_count == c_LAST_STEP) begin
            r_wrData <= w_result;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (bus.wbReady) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (r_state == IDLE);
  assign bus.busy     = (r_state != IDLE);
  assign bus.wrData   = r_wrData;
  assign bus.wrNum    = r_dst;
  assign bus.wrEnable = (r_state == DONE) && bus.wbReady && !bus.flush &&
                        (r_dst != '0);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Directed self-checking bench for mul_div_unit with a reference
//          arithmetic model and a per-cycle write-back monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.DATA_WIDTH(32), .REG_NUM_WIDTH(5)) bus ();

  mul_div_unit #(.DATA_WIDTH(32), .REG_NUM_WIDTH(5)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned wrCount = 0;
  logic        expValid = 1'b0;
  logic [31:0] expData = '0;
  logic [4:0]  expNum = '0;
  int unsigned expCyc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic [31:0] exp;
    int          stall;
    bit          poke;
  } vec_t;

  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference arithmetic straight from the M-extension rules
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: begin
        if (b == 0) p = 64'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = ua;
        else p = sa / sb;
      end
      3'd5: p = (b == 0) ? 64'hFFFFFFFF : ua / ub;
      3'd6: begin
        if (b == 0) p = ua;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = 0;
        else p = sa % sb;
      end
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  always @(negedge clk) begin
    if (cyc > 0 && rstN) check("busy_vs_ready", 64'(bus.busy), 64'(!bus.ready));
    if (bus.wrEnable === 1'b1) begin
      wrCount <= wrCount + 1;
      check("write_expected", 64'(expValid), 64'd1);
      if (expValid) begin
        check("wr_data", 64'(bus.wrData), 64'(expData));
        check("wr_num", 64'(bus.wrNum), 64'(expNum));
        check("wr_cycle", 64'(cyc), 64'(expCyc));
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int k = 0; k < 100 && bus.ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(bus.ready), 64'd1);
  endtask

  // Issue at posedge+1; returns with n = cycle number of CALC cycle 1
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, output int unsigned n);
    bus.op = op; bus.srcA = a; bus.srcB = b; bus.dstNum = dst; bus.start = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    bus.start = 1'b0;
    bus.srcA = $urandom(); bus.srcB = $urandom();
    bus.op = 3'($urandom_range(0, 7)); bus.dstNum = 5'($urandom_range(0, 31));
  endtask

  task automatic run_op(input int idx, input vec_t v);
    int unsigned n, wr0;
    logic [31:0] m;
    m = model(v.op, v.a, v.b);
    check($sformatf("model_v%0d", idx), 64'(m), 64'(v.exp));
    wait_ready($sformatf("ready_before_v%0d", idx));
    bus.wbReady = (v.stall == 0);
    expValid = (v.dst != 0); expData = m; expNum = v.dst;
    wr0 = wrCount;
    issue(v.op, v.a, v.b, v.dst, n);
    expCyc = n + 32 + v.stall;
    if (v.poke) begin
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = 3'd0; bus.srcA = 32'd99; bus.srcB = 32'd99; bus.dstNum = 5'd20;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    while (cyc < n + 32) begin
      @(posedge clk); #1;
    end
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check($sformatf("stall_wren_v%0d", idx), 64'(bus.wrEnable), 64'd0);
      check($sformatf("stall_data_v%0d", idx), 64'(bus.wrData), 64'(m));
      @(posedge clk); #1;
    end
    bus.wbReady = 1'b1;
    for (int k = 0; k < 10 && bus.ready !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    check($sformatf("ready_cycle_v%0d", idx), 64'(cyc - n), 64'(33 + v.stall));
    check($sformatf("write_count_v%0d", idx), 64'(wrCount - wr0), 64'(v.dst != 0));
    expValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n, wr0;
    bus.start = 1'b0; bus.op = '0; bus.srcA = '0; bus.srcB = '0; bus.dstNum = '0;
    bus.flush = 1'b0; bus.wbReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_wren", 64'(bus.wrEnable), 64'd0);
    check("rst_wrdata", 64'(bus.wrData), 64'd0);
    check("rst_wrnum", 64'(bus.wrNum), 64'd0);
    @(posedge clk); #1;

    vecs.push_back('{3'd0, 32'd7,         32'd6,         5'd5,  32'd42,        0, 1'b0});
    vecs.push_back('{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd1,  32'h00000000,  0, 1'b0});
    vecs.push_back('{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd2,  32'hFFFFFFFE,  0, 1'b0});
    vecs.push_back('{3'd2, 32'hFFFFFFFF,  32'd2,         5'd3,  32'hFFFFFFFF,  0, 1'b0});
    vecs.push_back('{3'd4, 32'hFFFFFFF9,  32'd2,         5'd4,  32'hFFFFFFFD,  0, 1'b0});
    vecs.push_back('{3'd6, 32'hFFFFFFF9,  32'd2,         5'd6,  32'hFFFFFFFF,  0, 1'b0});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        0, 1'b0});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         0, 1'b0});
    vecs.push_back('{3'd4, 32'h12345678,  32'd0,         5'd9,  32'hFFFFFFFF,  0, 1'b0});
    vecs.push_back('{3'd6, 32'h12345678,  32'd0,         5'd10, 32'h12345678,  0, 1'b0});
    vecs.push_back('{3'd4, 32'h80000000,  32'hFFFFFFFF,  5'd11, 32'h80000000,  0, 1'b0});
    vecs.push_back('{3'd6, 32'h80000000,  32'hFFFFFFFF,  5'd12, 32'h00000000,  0, 1'b0});
    vecs.push_back('{3'd3, 32'h80000000,  32'd4,         5'd13, 32'd2,         5, 1'b0});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd0,  32'd14,        0, 1'b0});
    vecs.push_back('{3'd0, 32'd3,         32'd5,         5'd14, 32'd15,        0, 1'b1});
    vecs.push_back('{3'd4, 32'd7,         32'hFFFFFFFE,  5'd15, 32'hFFFFFFFD,  0, 1'b0});
    vecs.push_back('{3'd6, 32'd7,         32'hFFFFFFFE,  5'd16, 32'd1,         0, 1'b0});
    vecs.push_back('{3'd1, 32'h80000000,  32'h80000000,  5'd17, 32'h40000000,  0, 1'b0});
    vecs.push_back('{3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  5'd18, 32'd1,         0, 1'b0});
    vecs.push_back('{3'd2, 32'hFFFFFFFE,  32'hFFFFFFFF,  5'd19, 32'hFFFFFFFE,  0, 1'b0});

    foreach (vecs[i]) run_op(i, vecs[i]);

    // Flush during CALC cycle 10
    wait_ready("ready_before_flush_calc");
    expValid = 1'b0; wr0 = wrCount;
    issue(3'd5, 32'd100, 32'd7, 5'd3, n);
    while (cyc < n + 9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_calc_ready", 64'(bus.ready), 64'd1);
    check("flush_calc_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_calc_nowrite", 64'(wrCount - wr0), 64'd0);

    // Flush in the DONE cycle overrides the write
    wr0 = wrCount;
    issue(3'd0, 32'd7, 32'd6, 5'd5, n);
    while (cyc < n + 32) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_wren", 64'(bus.wrEnable), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_done_ready", 64'(bus.ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("flush_done_nowrite", 64'(wrCount - wr0), 64'd0);

    // Reset while stalled in DONE
    bus.wbReady = 1'b0; wr0 = wrCount;
    issue(3'd0, 32'd7, 32'd6, 5'd5, n);
    while (cyc < n + 32) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_done_pre_data", 64'(bus.wrData), 64'd42);
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("rst_done_ready", 64'(bus.ready), 64'd1);
    check("rst_done_busy", 64'(bus.busy), 64'd0);
    check("rst_done_wren", 64'(bus.wrEnable), 64'd0);
    check("rst_done_wrdata", 64'(bus.wrData), 64'd0);
    check("rst_done_wrnum", 64'(bus.wrNum), 64'd0);
    bus.wbReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done_nowrite", 64'(wrCount - wr0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
